pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single DPI physical-memory port (raddr/rvalid/rdata, waddr/wdata/mask, device-visit flag) between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Converts the memory model's combinational access into a registered valid/ready request/response protocol with a configurable emulated latency.
- Guarantees each write mask is presented to the memory for exactly one cycle, so the combinational DPI write fires once per store.
- Sits between IFU/LSU and the Pmem instance in the core top level.

Parameters:
- LATENCY, 0, extra wait cycles inserted between request accept and memory access.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; mask width is DATA_W/8.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  arbiter can accept an IFU request this cycle.
- ifu_req_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  fetch data valid.
- ifu_resp_ready  in  1  IFU accepts response.
- ifu_resp_data  out  DATA_W  fetched data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  arbiter can accept an LSU request this cycle.
- lsu_req_addr  in  ADDR_W  load/store address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  store byte mask.
- lsu_resp_valid  out  1  load data or store ack valid.
- lsu_resp_ready  in  1  LSU accepts response.
- lsu_resp_data  out  DATA_W  load data; 0 for stores.
- lsu_resp_device  out  1  the access hit an MMIO device (difftest skip).
- mem_raddr  out  ADDR_W  to Pmem raddr.
- mem_rvalid  out  1  to Pmem rvalid.
- mem_waddr  out  ADDR_W  to Pmem waddr.
- mem_wdata  out  DATA_W  to Pmem wdata.
- mem_mask  out  DATA_W/8  to Pmem mask.
- mem_rdata  in  DATA_W  from Pmem rdata.
- mem_visit  in  1  from Pmem visit_advice.

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Reset (reset=0, asynchronous) forces:
  - state = IDLE;
  - all resp_valid/resp_data/resp_device = 0;
  - all mem_* outputs = 0;
  - round-robin pointer set to favour LSU.
- A reset mid-operation drops the in-flight request with no memory write issued.
- ifu_req_ready and lsu_req_ready are combinational and asserted only in IDLE. Only the granted requester sees ready=1, so at most one handshake occurs per cycle.
- Grant in IDLE:
  - If a single requester is valid, it is granted.
  - If both are valid, the requester favoured by the pointer is granted, and the pointer flips to the other requester.
  - The pointer also flips after any single-requester grant, so the loser always wins the next collision.
- On handshake, latch the owner (IFU/LSU), addr, wen, wdata and wmask.
  - An IFU request has wen forced to 0.
  - Next state: WAIT with counter = LATENCY if LATENCY > 0; otherwise ACCESS directly.
- WAIT: decrement the counter each cycle; move to ACCESS on the cycle the counter reads 1.
- ACCESS (exactly one cycle):
  - Load/fetch: mem_rvalid=1, mem_raddr=addr, mem_mask=0.
  - Store: mem_rvalid=0, mem_waddr=addr, mem_wdata=wdata, mem_mask=wmask.
  - Register resp_data (mem_rdata for loads, 0 for stores) and resp_device (mem_visit) at the clock edge.
  - Go to RESP.
- Outside ACCESS, all mem_* outputs are 0 (no spurious DPI read or write).
- RESP:
  - The owner's resp_valid=1 and holds data stable until that owner's resp_ready=1; then go to IDLE.
  - The non-owner's resp_valid stays 0.
  - ifu_resp_device does not exist; the device flag applies to LSU only.
- Latency: request accept at edge N → resp_valid high from cycle N+LATENCY+2.
- Throughput: one transaction per LATENCY+3 cycles minimum, because the IDLE accept cycle is not overlapped with RESP.
- A store with wmask=0 still traverses all states and is acked; the memory sees mask=0 (no write).
- Requests arriving while not in IDLE are not accepted; requesters hold valid with stable payload.
- Counter width is max(1, clog2(LATENCY+1)).

Test Plan:
- LATENCY=0, IFU fetch of 0x80000000, memory returns 0x00000413_00000297 → ifu_resp_valid at cycle 2 after accept with that data; mem_rvalid high for exactly 1 cycle.
- LSU store to 0x80001000, wdata 0x1122334455667788, wmask 0x0F → mem_mask=0x0F for exactly one cycle; lsu_resp_valid with data 0.
- IFU and LSU both valid in the same cycle after reset → LSU granted first; on the next collision IFU wins; neither starves over 10 back-to-back collisions.
- LATENCY=3, LSU load from 0xa0000048 with mem_visit=1 → lsu_resp_valid at cycle 5 after accept with lsu_resp_device=1; a load from 0x80000000 returns device=0.
- Hold lsu_resp_ready=0 for 4 cycles in RESP → data stays stable, both req_ready stay 0; release → IDLE next cycle.
- Assert reset during WAIT of a store → mem_mask never nonzero, all outputs 0, next request is accepted normally.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Request/response and physical-memory signal bundle shared by IFU, LSU and the arbiter.
// The arbiter connects through the slave modport; requesters and the memory model use master.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_resp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_resp_data;
  logic              lsu_resp_device;

  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_rvalid;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_visit;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  mem_rdata, mem_visit,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_device,
    output mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_mask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output mem_rdata, mem_visit,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_device,
    input  mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin IFU/LSU arbiter in front of the combinational pmem port; response LATENCY+2 cycles
// after accept, one transaction in flight, requests held off (ready=0) outside IDLE.
module pmem_arbiter #(
  parameter int LATENCY = 0,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  pmem_arbiter_if.slave   bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t            state;
  logic              ptr_lsu;
  logic              own_lsu;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic              ifu_resp_valid, lsu_resp_valid, lsu_resp_device;
  logic [DATA_W-1:0] ifu_resp_data, lsu_resp_data;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;

  logic              idle, grant_lsu, grant_ifu, enter_access;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wen;
  logic [DATA_W-1:0] acc_wdata;
  logic [MASK_W-1:0] acc_wmask;

  assign idle      = (state == IDLE);
  assign grant_lsu = idle && bus.lsu_req_valid && (ptr_lsu || !bus.ifu_req_valid);
  assign grant_ifu = idle && bus.ifu_req_valid && !(bus.lsu_req_valid && ptr_lsu);

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;

  // With zero latency the memory is driven straight from the request being accepted.
  always_comb begin
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (idle) begin
      acc_addr  = grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
      acc_wen   = grant_lsu && bus.lsu_req_wen;
      acc_wdata = grant_lsu ? bus.lsu_req_wdata : '0;
      acc_wmask = grant_lsu ? bus.lsu_req_wmask : '0;
    end
  end

  assign enter_access = (idle && (grant_lsu || grant_ifu) && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ptr_lsu         <= 1'b1;
      own_lsu         <= 1'b0;
      cnt             <= '0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      ifu_resp_valid  <= 1'b0;
      ifu_resp_data   <= '0;
      lsu_resp_valid  <= 1'b0;
      lsu_resp_data   <= '0;
      lsu_resp_device <= 1'b0;
      mem_raddr       <= '0;
      mem_rvalid      <= 1'b0;
      mem_waddr       <= '0;
      mem_wdata       <= '0;
      mem_mask        <= '0;
    end else begin
      // Memory strobes live for the single ACCESS cycle only.
      mem_raddr  <= '0;
      mem_rvalid <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
      if (enter_access) begin
        mem_rvalid <= !acc_wen;
        mem_raddr  <= acc_wen ? '0 : acc_addr;
        mem_waddr  <= acc_wen ? acc_addr : '0;
        mem_wdata  <= acc_wen ? acc_wdata : '0;
        mem_mask   <= acc_wen ? acc_wmask : '0;
      end

      case (state)
        IDLE: begin
          if (grant_lsu || grant_ifu) begin
            own_lsu <= grant_lsu;
            ptr_lsu <= grant_ifu;
            addr_q  <= acc_addr;
            wen_q   <= acc_wen;
            wdata_q <= acc_wdata;
            wmask_q <= acc_wmask;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY);
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ACCESS;
        end
        ACCESS: begin
          if (own_lsu) begin
            lsu_resp_valid  <= 1'b1;
            lsu_resp_data   <= wen_q ? '0 : bus.mem_rdata;
            lsu_resp_device <= bus.mem_visit;
          end else begin
            ifu_resp_valid <= 1'b1;
            ifu_resp_data  <= bus.mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          if (own_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifu_resp_valid  = ifu_resp_valid;
  assign bus.ifu_resp_data   = ifu_resp_data;
  assign bus.lsu_resp_valid  = lsu_resp_valid;
  assign bus.lsu_resp_data   = lsu_resp_data;
  assign bus.lsu_resp_device = lsu_resp_device;
  assign bus.mem_raddr       = mem_raddr;
  assign bus.mem_rvalid      = mem_rvalid;
  assign bus.mem_waddr       = mem_waddr;
  assign bus.mem_wdata       = mem_wdata;
  assign bus.mem_mask        = mem_mask;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a LATENCY=0 and a LATENCY=3 instance share one set of request drivers,
// with sel choosing which instance sees valid; a small memory model answers both.
module tb_pmem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if0 ();
  pmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if3 ();

  pmem_arbiter #(.LATENCY(0), .ADDR_W(64), .DATA_W(64)) dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
  pmem_arbiter #(.LATENCY(3), .ADDR_W(64), .DATA_W(64)) dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

  logic        sel = 1'b0;
  logic        ifu_v = 1'b0, lsu_v = 1'b0, lsu_wen = 1'b0;
  logic        ifu_rr = 1'b1, lsu_rr = 1'b1;
  logic [63:0] ifu_a = '0, lsu_a = '0, lsu_wd = '0;
  logic [7:0]  lsu_wm = '0;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00000413_00000297;
    return {a[31:0], ~a[31:0]};
  endfunction

  function automatic logic visit_model(input logic rv, input logic [63:0] ra,
                                       input logic [63:0] wa, input logic [7:0] m);
    if (rv) return ra[31:28] == 4'ha;
    if (m != 8'h00) return wa[31:28] == 4'ha;
    return 1'b0;
  endfunction

  assign if0.ifu_req_valid  = ifu_v && !sel;
  assign if0.lsu_req_valid  = lsu_v && !sel;
  assign if3.ifu_req_valid  = ifu_v && sel;
  assign if3.lsu_req_valid  = lsu_v && sel;
  assign if0.ifu_req_addr   = ifu_a;
  assign if3.ifu_req_addr   = ifu_a;
  assign if0.lsu_req_addr   = lsu_a;
  assign if3.lsu_req_addr   = lsu_a;
  assign if0.lsu_req_wen    = lsu_wen;
  assign if3.lsu_req_wen    = lsu_wen;
  assign if0.lsu_req_wdata  = lsu_wd;
  assign if3.lsu_req_wdata  = lsu_wd;
  assign if0.lsu_req_wmask  = lsu_wm;
  assign if3.lsu_req_wmask  = lsu_wm;
  assign if0.ifu_resp_ready = ifu_rr;
  assign if3.ifu_resp_ready = ifu_rr;
  assign if0.lsu_resp_ready = lsu_rr;
  assign if3.lsu_resp_ready = lsu_rr;
  assign if0.mem_rdata = mem_model(if0.mem_raddr);
  assign if3.mem_rdata = mem_model(if3.mem_raddr);
  assign if0.mem_visit = visit_model(if0.mem_rvalid, if0.mem_raddr, if0.mem_waddr, if0.mem_mask);
  assign if3.mem_visit = visit_model(if3.mem_rvalid, if3.mem_raddr, if3.mem_waddr, if3.mem_mask);

  logic        ifu_rdy, lsu_rdy, ifu_rv, lsu_rv, lsu_dev;
  logic [63:0] ifu_rd, lsu_rd;
  assign ifu_rdy = sel ? if3.ifu_req_ready   : if0.ifu_req_ready;
  assign lsu_rdy = sel ? if3.lsu_req_ready   : if0.lsu_req_ready;
  assign ifu_rv  = sel ? if3.ifu_resp_valid  : if0.ifu_resp_valid;
  assign lsu_rv  = sel ? if3.lsu_resp_valid  : if0.lsu_resp_valid;
  assign lsu_dev = sel ? if3.lsu_resp_device : if0.lsu_resp_device;
  assign ifu_rd  = sel ? if3.ifu_resp_data   : if0.ifu_resp_data;
  assign lsu_rd  = sel ? if3.lsu_resp_data   : if0.lsu_resp_data;

  // Memory-side activity seen by each instance, sampled mid-cycle.
  int          rd_cnt0 = 0, rd_cnt3 = 0, wr_cnt0 = 0, wr_cnt3 = 0;
  logic [7:0]  last_mask0 = '0, last_mask3 = '0;
  logic [63:0] last_waddr0 = '0, last_waddr3 = '0, last_wdata0 = '0, last_wdata3 = '0;
  always @(negedge clock) begin
    if (if0.mem_rvalid) rd_cnt0++;
    if (if3.mem_rvalid) rd_cnt3++;
    if (if0.mem_mask != 8'h00) begin
      wr_cnt0++; last_mask0 = if0.mem_mask; last_waddr0 = if0.mem_waddr; last_wdata0 = if0.mem_wdata;
    end
    if (if3.mem_mask != 8'h00) begin
      wr_cnt3++; last_mask3 = if3.mem_mask; last_waddr3 = if3.mem_waddr; last_wdata3 = if3.mem_wdata;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dsel;
    logic        is_lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_data;
    logic        exp_dev;
  } vec_t;

  vec_t vecs[11];

  task automatic txn(input int idx, input vec_t v);
    int  rd_b, wr_b, lat;
    bit  got;
    rd_b = sel ? rd_cnt3 : rd_cnt0;
    wr_b = sel ? wr_cnt3 : wr_cnt0;
    @(negedge clock);
    if (v.is_lsu) begin
      lsu_a = v.addr; lsu_wen = v.wen; lsu_wd = v.wdata; lsu_wm = v.wmask; lsu_v = 1'b1;
    end else begin
      ifu_a = v.addr; ifu_v = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (v.is_lsu ? lsu_rdy : ifu_rdy) got = 1;
      else @(negedge clock);
    end
    chk($sformatf("v%0d_accept", idx), 64'(got), 64'd1);
    @(posedge clock);
    #1;
    ifu_v = 1'b0; lsu_v = 1'b0;
    got = 0; lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clock);
      if (v.is_lsu ? lsu_rv : ifu_rv) begin got = 1; lat = i; end
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), sel ? 64'd5 : 64'd2);
    if (v.is_lsu) begin
      chk($sformatf("v%0d_data", idx), lsu_rd, v.exp_data);
      chk($sformatf("v%0d_device", idx), 64'(lsu_dev), 64'(v.exp_dev));
      chk($sformatf("v%0d_other_valid", idx), 64'(ifu_rv), 64'd0);
    end else begin
      chk($sformatf("v%0d_data", idx), ifu_rd, v.exp_data);
      chk($sformatf("v%0d_other_valid", idx), 64'(lsu_rv), 64'd0);
    end
    @(posedge clock);
    #1;
    chk($sformatf("v%0d_rd_pulses", idx), 64'((sel ? rd_cnt3 : rd_cnt0) - rd_b), v.wen ? 64'd0 : 64'd1);
    chk($sformatf("v%0d_wr_pulses", idx), 64'((sel ? wr_cnt3 : wr_cnt0) - wr_b),
        (v.wen && v.wmask != 8'h00) ? 64'd1 : 64'd0);
    if (v.wen && v.wmask != 8'h00) begin
      chk($sformatf("v%0d_wmask", idx), 64'(sel ? last_mask3 : last_mask0), 64'(v.wmask));
      chk($sformatf("v%0d_waddr", idx), sel ? last_waddr3 : last_waddr0, v.addr);
      chk($sformatf("v%0d_wdata", idx), sel ? last_wdata3 : last_wdata0, v.wdata);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int nl, ni, wr_b;
    logic [63:0] hold_exp;

    vecs[0]  = '{1'b0, 1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h00000413_00000297, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 64'h8000_1000, 1'b1, 64'h1122334455667788, 8'h0F, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 64'h8000_0008, 1'b0, 64'h0, 8'h00, 64'h80000008_7ffffff7, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 64'ha000_0048, 1'b0, 64'h0, 8'h00, 64'ha0000048_5fffffb7, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 64'ha000_0010, 1'b1, 64'hdeadbeef, 8'h00, 64'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h80000010_7fffffef, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'ha000_03f8, 1'b1, 64'hcafef00d, 8'hFF, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 64'ha000_0048, 1'b0, 64'h0, 8'h00, 64'ha0000048_5fffffb7, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h00000413_00000297, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 64'h8000_3000, 1'b1, 64'h0102030405060708, 8'hF0, 64'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h80000004_7ffffffb, 1'b0};

    // Reset values while reset is held low.
    @(negedge clock);
    chk("rst_ifu_resp_valid", 64'(if0.ifu_resp_valid), 64'd0);
    chk("rst_lsu_resp_valid", 64'(if0.lsu_resp_valid), 64'd0);
    chk("rst_lsu_resp_data", if0.lsu_resp_data, 64'd0);
    chk("rst_mem_rvalid", 64'(if0.mem_rvalid), 64'd0);
    chk("rst_mem_mask", 64'(if0.mem_mask), 64'd0);
    chk("rst3_lsu_resp_device", 64'(if3.lsu_resp_device), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) begin
      sel = vecs[k].dsel;
      txn(k, vecs[k]);
    end

    // Back-to-back collisions: LSU first after reset, then strict alternation.
    sel = 1'b0;
    pulse_reset();
    ifu_a = 64'h8000_0020; lsu_a = 64'h8000_0040; lsu_wen = 1'b0; lsu_wm = 8'h00;
    ifu_v = 1'b1; lsu_v = 1'b1;
    nl = 0; ni = 0;
    for (int g = 0; g < 10; g++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        #1;
        if (ifu_rdy || lsu_rdy) got = 1;
        else @(negedge clock);
      end
      chk($sformatf("coll%0d_wait", g), 64'(got), 64'd1);
      chk($sformatf("coll%0d_one_ready", g), 64'(ifu_rdy && lsu_rdy), 64'd0);
      chk($sformatf("coll%0d_lsu_grant", g), 64'(lsu_rdy), 64'(g % 2 == 0));
      if (lsu_rdy) nl++;
      else if (ifu_rdy) ni++;
      @(negedge clock);
    end
    ifu_v = 1'b0; lsu_v = 1'b0;
    repeat (4) @(negedge clock);
    chk("coll_lsu_grants", 64'(nl), 64'd5);
    chk("coll_ifu_grants", 64'(ni), 64'd5);

    // Response held off for 4 cycles while IFU waits.
    hold_exp = 64'h80000008_7ffffff7;
    @(negedge clock);
    lsu_rr = 1'b0; lsu_a = 64'h8000_0008; lsu_wen = 1'b0; lsu_v = 1'b1;
    #1;
    chk("hold_accept", 64'(lsu_rdy), 64'd1);
    @(posedge clock);
    #1;
    lsu_v = 1'b0; ifu_a = 64'h8000_0000; ifu_v = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (lsu_rv) got = 1;
    end
    chk("hold_resp_seen", 64'(got), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      chk($sformatf("hold%0d_valid", i), 64'(lsu_rv), 64'd1);
      chk($sformatf("hold%0d_data", i), lsu_rd, hold_exp);
      chk($sformatf("hold%0d_ready", i), 64'({ifu_rdy, lsu_rdy}), 64'd0);
    end
    lsu_rr = 1'b1;
    @(negedge clock);
    chk("hold_release_valid", 64'(lsu_rv), 64'd0);
    chk("hold_release_idle", 64'(ifu_rdy), 64'd1);
    ifu_v = 1'b0;

    // Reset while a store on the LATENCY=3 instance is in WAIT.
    sel = 1'b1;
    wr_b = wr_cnt3;
    @(negedge clock);
    lsu_a = 64'h8000_2000; lsu_wen = 1'b1; lsu_wd = 64'h5555aaaa5555aaaa; lsu_wm = 8'hFF; lsu_v = 1'b1;
    #1;
    chk("rstw_accept", 64'(lsu_rdy), 64'd1);
    @(posedge clock);
    #1;
    lsu_v = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rstw_mem_mask", 64'(if3.mem_mask), 64'd0);
    chk("rstw_mem_rvalid", 64'(if3.mem_rvalid), 64'd0);
    chk("rstw_lsu_resp_valid", 64'(if3.lsu_resp_valid), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("rstw_no_write", 64'(wr_cnt3 - wr_b), 64'd0);

    for (int k = 7; k < 11; k++) begin
      sel = vecs[k].dsel;
      txn(k, vecs[k]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
